bist_tpg_ctrl: RTL and testbench

- Stimulus-side companion to the team's 16-bit serial MISR. It generates the BIST test sequence and checks the resulting signature.
- A 16-bit internal-XOR LFSR emits one pseudo-random bit per cycle to the circuit under test for a programmable number of patterns.
- After the run it holds the MISR enable for a flush window, compares the MISR signature against a golden value, and reports done/pass.
- Sits between the BIST top level and the CUT/MISR pair.

---
 rtl/bist_tpg_ctrl.sv | 150 +++++++++++++++
 tb/tb_bist_tpg_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_tpg_ctrl.sv
// BIST stimulus controller: drives a 16-bit internal-XOR LFSR bit stream into the CUT,
// holds the MISR enable through a flush window, then checks the signature against a golden value.
module bist_tpg_ctrl #(
    parameter int unsigned N_PATTERNS   = 1000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [15:0] SEED         = 16'hFFFF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed_in,
    input  logic [15:0]      golden_sig,
    input  logic [15:0]      sig_in,
    output logic             pattern_out,
    output logic             pattern_valid,
    output logic             misr_en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      lfsr_state,
    output logic [CNT_W-1:0] pattern_count
);

    localparam int unsigned LFSR_W  = 16;
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(N_PATTERNS - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [LFSR_W-1:0]  seed_q, seed_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               pattern_valid_q, pattern_valid_d;
    logic               misr_en_q, misr_en_d;
    logic [LFSR_W-1:0]  load_val;

    // Same taps as the companion MISR (bits 0, 9, 14), no data injection.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        logic              fb;
        fb    = s[LFSR_W-1];
        n     = {s[LFSR_W-2:0], fb};
        n[9]  = s[8] ^ fb;
        n[14] = s[13] ^ fb;
        return n;
    endfunction

    always_comb begin
        state_d         = state_q;
        seed_d          = seed_q;
        lfsr_d          = lfsr_q;
        cnt_d           = cnt_q;
        flush_d         = flush_q;
        pass_d          = pass_q;
        load_val        = (seed_in == '0) ? SEED : seed_in;

        case (state_q)
            S_IDLE, S_DONE: begin
                // seed_load has priority over start in the same cycle
                if (seed_load) begin
                    seed_d = load_val;
                    lfsr_d = load_val;
                end else if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = seed_q;
                    cnt_d   = '0;
                    flush_d = '0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    flush_d = '0;
                    state_d = (FLUSH_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            S_CHECK: begin
                pass_d  = (sig_in == golden_sig);
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags decode the upcoming state so they are flop outputs aligned with it.
        pattern_valid_d = (state_d == S_RUN);
        misr_en_d       = (state_d == S_RUN) || (state_d == S_SETTLE);
        busy_d          = (state_d == S_RUN) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d          = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            seed_q          <= SEED;
            lfsr_q          <= SEED;
            cnt_q           <= '0;
            flush_q         <= '0;
            pass_q          <= 1'b0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            pattern_valid_q <= 1'b0;
            misr_en_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            seed_q          <= seed_d;
            lfsr_q          <= lfsr_d;
            cnt_q           <= cnt_d;
            flush_q         <= flush_d;
            pass_q          <= pass_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            pattern_valid_q <= pattern_valid_d;
            misr_en_q       <= misr_en_d;
        end
    end

    assign pattern_out   = lfsr_q[LFSR_W-1];
    assign pattern_valid = pattern_valid_q;
    assign misr_en       = misr_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign lfsr_state    = lfsr_q;
    assign pattern_count = cnt_q;

endmodule

// File: tb/tb_bist_tpg_ctrl.sv
// Testbench for bist_tpg_ctrl: two configurations driven by shared stimulus, checked each
// cycle against a timeline-based reference model plus directed literal expectations.
module tb_bist_tpg_ctrl;

    localparam int unsigned N0 = 3;
    localparam int unsigned F0 = 0;
    localparam int unsigned N1 = 7;
    localparam int unsigned F1 = 2;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic        clk, rst_n, start, seed_load;
    logic [15:0] seed_in, golden_sig, sig_in;

    logic        po0, pv0, me0, bz0, dn0, ps0;
    logic        po1, pv1, me1, bz1, dn1, ps1;
    logic [15:0] ls0, ls1, pc0, pc1;

    int checks = 0;
    int errors = 0;

    bist_tpg_ctrl #(.N_PATTERNS(N0), .FLUSH_CYCLES(F0), .SEED(SEED), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
        .golden_sig(golden_sig), .sig_in(sig_in), .pattern_out(po0), .pattern_valid(pv0),
        .misr_en(me0), .busy(bz0), .done(dn0), .pass(ps0), .lfsr_state(ls0), .pattern_count(pc0)
    );

    bist_tpg_ctrl #(.N_PATTERNS(N1), .FLUSH_CYCLES(F1), .SEED(SEED), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load), .seed_in(seed_in),
        .golden_sig(golden_sig), .sig_in(sig_in), .pattern_out(po1), .pattern_valid(pv1),
        .misr_en(me1), .busy(bz1), .done(dn1), .pass(ps1), .lfsr_state(ls1), .pattern_count(pc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned n_of(input int i);
        return (i == 0) ? N0 : N1;
    endfunction

    function automatic int unsigned f_of(input int i);
        return (i == 0) ? F0 : F1;
    endfunction

    // Polynomial multiply-by-x modulo the feedback mask (bits 0, 9, 14).
    function automatic logic [15:0] mdl_step(input logic [15:0] s);
        return s[15] ? ((s << 1) ^ 16'h4201) : (s << 1);
    endfunction

    // Reference model: a run is a timeline t = 0.. since start; N pattern cycles,
    // F flush cycles, one check cycle, then done.
    logic        m_act  [2];
    int          m_t    [2];
    logic        m_done [2];
    logic        m_pass [2];
    logic [15:0] m_seed [2];
    logic [15:0] m_lfsr [2];
    logic [15:0] m_cnt  [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_done[i] <= 1'b0;
                m_pass[i] <= 1'b0;
                m_seed[i] <= SEED;
                m_lfsr[i] <= SEED;
                m_cnt[i]  <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    if (m_t[i] < int'(n_of(i))) begin
                        m_lfsr[i] <= mdl_step(m_lfsr[i]);
                        m_cnt[i]  <= m_cnt[i] + 16'd1;
                        m_t[i]    <= m_t[i] + 1;
                    end else if (m_t[i] < int'(n_of(i) + f_of(i))) begin
                        m_t[i] <= m_t[i] + 1;
                    end else begin
                        m_pass[i] <= (sig_in == golden_sig);
                        m_done[i] <= 1'b1;
                        m_act[i]  <= 1'b0;
                    end
                end else if (seed_load) begin
                    m_seed[i] <= (seed_in == 16'd0) ? SEED : seed_in;
                    m_lfsr[i] <= (seed_in == 16'd0) ? SEED : seed_in;
                end else if (start) begin
                    m_act[i]  <= 1'b1;
                    m_t[i]    <= 0;
                    m_lfsr[i] <= m_seed[i];
                    m_cnt[i]  <= 16'd0;
                    m_done[i] <= 1'b0;
                    m_pass[i] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input logic po, input logic pv, input logic me,
                            input logic bz, input logic dn, input logic ps,
                            input logic [15:0] ls, input logic [15:0] pc);
        logic epv, eme;
        epv = m_act[i] && (m_t[i] < int'(n_of(i)));
        eme = m_act[i] && (m_t[i] < int'(n_of(i) + f_of(i)));
        check($sformatf("dut%0d.pattern_valid", i), 32'(pv), 32'(epv));
        check($sformatf("dut%0d.misr_en", i), 32'(me), 32'(eme));
        check($sformatf("dut%0d.busy", i), 32'(bz), 32'(m_act[i]));
        check($sformatf("dut%0d.done", i), 32'(dn), 32'(m_done[i]));
        check($sformatf("dut%0d.pass", i), 32'(ps), 32'(m_pass[i]));
        check($sformatf("dut%0d.lfsr_state", i), 32'(ls), 32'(m_lfsr[i]));
        check($sformatf("dut%0d.pattern_count", i), 32'(pc), 32'(m_cnt[i]));
        if (epv) check($sformatf("dut%0d.pattern_out", i), 32'(po), 32'(m_lfsr[i][15]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp_inst(0, po0, pv0, me0, bz0, dn0, ps0, ls0, pc0);
            cmp_inst(1, po1, pv1, me1, bz1, dn1, ps1, ls1, pc1);
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!(dn0 && dn1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_done.timeout", 32'(dn0 && dn1), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [15:0] e_lfsr [4];
    logic        e_po   [3];

    initial begin
        e_lfsr[0] = 16'hFFFF; e_lfsr[1] = 16'hBDFF; e_lfsr[2] = 16'h39FF; e_lfsr[3] = 16'h73FE;
        e_po[0] = 1'b1; e_po[1] = 1'b1; e_po[2] = 1'b0;
        rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed_in = 16'd0;
        golden_sig = 16'h1234; sig_in = 16'h1234;
        repeat (3) @(negedge clk);
        check("reset.lfsr", 32'(ls0), 32'hFFFF);
        check("reset.flags", 32'({pv0, me0, bz0, dn0, ps0}), 32'd0);
        check("reset.count", 32'(pc0), 32'd0);
        rst_n = 1'b1;

        // Directed run, N=3 F=0: sequence FFFF->BDFF->39FF->73FE, bits 1,1,0
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("run1.lfsr[%0d]", k), 32'(ls0), 32'(e_lfsr[k]));
            check($sformatf("run1.pv[%0d]", k), 32'(pv0), (k < 3) ? 32'd1 : 32'd0);
            check($sformatf("run1.busy[%0d]", k), 32'(bz0), 32'd1);
            if (k < 3) check($sformatf("run1.po[%0d]", k), 32'(po0), 32'(e_po[k]));
            @(negedge clk);
        end
        check("run1.done", 32'(dn0), 32'd1);
        check("run1.pass", 32'(ps0), 32'd1);
        check("run1.busy_low", 32'(bz0), 32'd0);
        check("run1.count", 32'(pc0), 32'd3);
        wait_done();
        check("run1.pass1", 32'(ps1), 32'd1);

        // Mismatching golden signature
        golden_sig = 16'h1235;
        pulse_start();
        wait_done();
        check("run2.pass0", 32'(ps0), 32'd0);
        check("run2.pass1", 32'(ps1), 32'd0);
        golden_sig = 16'h1234;

        // Zero seed maps to default; seed 0001 starts with zero bits
        @(negedge clk); seed_load = 1'b1; seed_in = 16'h0000;
        @(negedge clk); seed_load = 1'b0;
        check("seed0.lfsr0", 32'(ls0), 32'hFFFF);
        check("seed0.lfsr1", 32'(ls1), 32'hFFFF);
        seed_load = 1'b1; seed_in = 16'h0001;
        @(negedge clk); seed_load = 1'b0;
        check("seed1.lfsr0", 32'(ls0), 32'h0001);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("seed1.po_first", 32'(po0), 32'd0);
        @(negedge clk);
        check("seed1.po_second", 32'(po0), 32'd0);
        check("seed1.lfsr_second", 32'(ls0), 32'h0002);
        // start/seed_load pulses while busy are ignored
        start = 1'b1; seed_load = 1'b1; seed_in = 16'hABCD;
        @(negedge clk); start = 1'b0; seed_load = 1'b0;
        wait_done();
        check("busy_ignore.lfsr0", 32'(ls0), 32'h0008);

        // start held high through DONE restarts from the same seed
        @(negedge clk); start = 1'b1;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_done();
        check("hold.lfsr0", 32'(ls0), 32'h0008);

        // Asynchronous reset mid-run at count==1
        pulse_start();
        @(negedge clk);
        check("midrst.count_before", 32'(pc0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.flags", 32'({pv0, me0, bz0, dn0, ps0}), 32'd0);
        check("midrst.lfsr", 32'(ls0), 32'hFFFF);
        check("midrst.count", 32'(pc0), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst.idle_busy", 32'(bz0), 32'd0);
        check("midrst.idle_done", 32'(dn0), 32'd0);

        // Randomized traffic against the model
        repeat (2000) begin
            @(negedge clk);
            start      = ($urandom_range(3) == 0);
            seed_load  = ($urandom_range(7) == 0);
            seed_in    = ($urandom_range(3) == 0) ? 16'd0 : 16'($urandom);
            sig_in     = 16'($urandom);
            golden_sig = ($urandom_range(1) == 0) ? sig_in : 16'($urandom);
        end
        @(negedge clk);
        start = 1'b0; seed_load = 1'b0;
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
